// File: rtl/psum_accumulator.sv
// Accumulates per-lane MAC tile results over k_len beats, then presents the
// saturated partial sums with latched scale/bias to the ppu and holds until ppu_done.
module psum_accumulator #(
  parameter int unsigned LANES  = 16,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned KLEN_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [KLEN_W-1:0]      k_len,
  input  logic [7:0]             scale_in,
  input  logic [7:0]             bias_in,
  input  logic                   mac_valid,
  output logic                   mac_ready,
  input  logic [LANES*ACC_W-1:0] mac_data,
  input  logic                   ppu_done,
  output logic [LANES*ACC_W-1:0] partial_sum,
  output logic [7:0]             scale,
  output logic [7:0]             bias,
  output logic                   psum_valid,
  output logic                   busy,
  output logic                   ovf
);

  localparam int unsigned DATA_W = LANES * ACC_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_EMIT  = 2'd2,
    S_WAIT  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [KLEN_W-1:0]   cnt_q, cnt_d;
  logic [KLEN_W-1:0]   klen_q, klen_d;
  logic [DATA_W-1:0]   psum_q, psum_d;
  logic [7:0]          scale_q, scale_d;
  logic [7:0]          bias_q, bias_d;
  logic                psum_valid_q, psum_valid_d;
  logic                mac_ready_q, mac_ready_d;
  logic                busy_q, busy_d;
  logic                ovf_q, ovf_d;

  logic [ACC_W:0]      lane_sum [LANES];
  logic [DATA_W-1:0]   lane_sat;
  logic [LANES-1:0]    lane_carry;
  logic [KLEN_W-1:0]   cnt_inc;
  logic                beat;

  assign beat    = mac_valid & mac_ready_q;
  assign cnt_inc = cnt_q + KLEN_W'(1);

  // Per-lane add with one guard bit; a carry clamps the lane to all-ones.
  always_comb begin
    lane_sat   = '0;
    lane_carry = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_sum[i] = {1'b0, psum_q[i*ACC_W +: ACC_W]} + {1'b0, mac_data[i*ACC_W +: ACC_W]};
      lane_carry[i] = lane_sum[i][ACC_W];
      lane_sat[i*ACC_W +: ACC_W] = lane_sum[i][ACC_W] ? {ACC_W{1'b1}} : lane_sum[i][ACC_W-1:0];
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    klen_d       = klen_q;
    psum_d       = psum_q;
    scale_d      = scale_q;
    bias_d       = bias_q;
    psum_valid_d = 1'b0;
    mac_ready_d  = mac_ready_q;
    busy_d       = busy_q;
    ovf_d        = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start && (k_len != '0)) begin
          klen_d      = k_len;
          scale_d     = scale_in;
          bias_d      = bias_in;
          psum_d      = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
          mac_ready_d = 1'b1;
          busy_d      = 1'b1;
          state_d     = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (beat) begin
          psum_d = lane_sat;
          ovf_d  = ovf_q | (|lane_carry);
          cnt_d  = cnt_inc;
          if (cnt_inc == klen_q) begin
            mac_ready_d  = 1'b0;
            psum_valid_d = 1'b1;
            state_d      = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ppu_done) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        mac_ready_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      klen_q       <= '0;
      psum_q       <= '0;
      scale_q      <= '0;
      bias_q       <= '0;
      psum_valid_q <= 1'b0;
      mac_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      klen_q       <= klen_d;
      psum_q       <= psum_d;
      scale_q      <= scale_d;
      bias_q       <= bias_d;
      psum_valid_q <= psum_valid_d;
      mac_ready_q  <= mac_ready_d;
      busy_q       <= busy_d;
      ovf_q        <= ovf_d;
    end
  end

  assign partial_sum = psum_q;
  assign scale       = scale_q;
  assign bias        = bias_q;
  assign psum_valid  = psum_valid_q;
  assign mac_ready   = mac_ready_q;
  assign busy        = busy_q;
  assign ovf         = ovf_q;

endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Sits directly upstream of the ppu.
- Accumulates per-lane MAC tile results over a programmable number of K-beats into 16 x 24-bit partial sums.
- Presents the finished vector, plus the latched scale and bias, to the ppu with a one-cycle valid.
- Holds everything stable until the ppu signals done, which serialises tiles into the post-processing pipeline.

Parameters:
- LANES, 16, number of accumulator lanes.
- ACC_W, 24, per-lane input and accumulator width (unsigned).
- KLEN_W, 8, width of the beat-count field.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  pulse; begins a new accumulation job
- k_len  input  KLEN_W  number of beats in the job; sampled on start
- scale_in  input  8  fp8 gamma; latched on start
- bias_in  input  8  bias; latched on start
- mac_valid  input  1  mac_data valid
- mac_ready  output  1  accumulator accepting beats
- mac_data  input  LANES*ACC_W  lane i at [i*ACC_W +: ACC_W]
- ppu_done  input  1  ppu finished consuming the current vector (ppu done_wire)
- partial_sum  output  LANES*ACC_W  accumulated vector to ppu; same lane packing
- scale  output  8  latched scale_in
- bias  output  8  latched bias_in
- psum_valid  output  1  one-cycle strobe to ppu valid
- busy  output  1  high whenever state != IDLE
- ovf  output  1  sticky: a lane saturated during the current job

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - Every output register is 0: partial_sum, scale, bias, psum_valid, mac_ready, busy, ovf.
  - The beat counter is 0.
  - Reset mid-job aborts the job with no output.
- State machine: IDLE -> ACCUM -> EMIT -> WAIT -> IDLE.
- IDLE:
  - mac_ready=0.
  - start=1 with k_len!=0 does all of the following on that edge:
    - latch k_len, scale_in and bias_in;
    - clear all lane accumulators and the counter;
    - clear ovf;
    - go to ACCUM.
  - start with k_len==0 is ignored; the block stays in IDLE with no outputs changed.
- ACCUM:
  - mac_ready=1 (registered, high from the first cycle in ACCUM).
  - A beat is accepted on any edge with mac_valid & mac_ready. For each lane, acc[i] <= min(acc[i]+mac_data[i], 2^ACC_W-1).
  - Addition is done at ACC_W+1 bits. A carry out clamps the lane to 0xFFFFFF and sets ovf.
  - Counter increments per accepted beat. Cycles without mac_valid do not count.
  - On the edge accepting beat number k_len:
    - the final sum is written;
    - mac_ready drops;
    - psum_valid is set;
    - state goes to EMIT.
  - psum_valid is therefore high in the cycle after the last beat edge (latency 1 cycle).
- EMIT:
  - Exactly one cycle with psum_valid=1.
  - partial_sum, scale and bias are valid and equal the final values.
  - Next edge: psum_valid=0, go to WAIT.
- WAIT:
  - mac_ready=0.
  - partial_sum, scale and bias are held unchanged.
  - ppu_done=1 returns the block to IDLE on the next edge, and busy falls.
  - partial_sum remains held in IDLE until the next accepted start.
- Ignored inputs:
  - ppu_done outside WAIT.
  - start outside IDLE; a second start mid-job has no effect on the counter, sums or latched fields.
  - mac_valid while mac_ready=0; the beat is dropped and nothing changes.
- start and ppu_done simultaneous in WAIT: ppu_done is taken and start is ignored. The new start must arrive in IDLE.
- ovf stays set through EMIT, WAIT and IDLE until the next accepted start.
- Counter wrap is not possible: a job of k_len=255 is 255 beats and the counter stops at k_len.

Test Plan:
1. Single-beat pass-through:
   - Stimulus: k_len=1, scale_in=0x65, bias_in=1; one beat with lanes 15..8=15008 and lanes 7..0=129794.
   - Required: psum_valid high for exactly 1 cycle, in the cycle after the beat edge; partial_sum identical to the beat; scale=0x65, bias=1; ovf=0; busy stays high until ppu_done.
2. Multi-beat accumulation with gaps:
   - Stimulus: k_len=4; four beats of 3752 in every lane, separated by 0-3 idle cycles of mac_valid=0.
   - Required: every lane=15008; psum_valid only after the 4th accepted beat; idle cycles do not count.
3. Saturation:
   - Stimulus: k_len=2; beats 0xF00000 then 0x200000 in lane 5, 1 in all other lanes.
   - Required: lane 5=0xFFFFFF, other lanes=2, ovf=1. The next accepted start clears ovf to 0.
4. Handshake and hold:
   - Stimulus: after EMIT, drive mac_valid=1 with mac_data=0x000100 per lane and start=1 for 10 cycles, with ppu_done=0.
   - Required: mac_ready=0, partial_sum unchanged, state WAIT. After a ppu_done pulse: busy=0 next cycle; a subsequent start begins a fresh job from zero.
5. Illegal start: start with k_len=0 -> busy stays 0, no psum_valid, outputs unchanged.
6. Reset mid-job:
   - Stimulus: k_len=4, 2 beats accepted, then rst_n low asynchronously.
   - Required: all outputs 0 immediately, with no psum_valid. After release, a new k_len=1 job with 7 per lane yields exactly 7 per lane.
